jtag_scan_master: RTL and testbench
===================================

JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 SHALL have ports: TCLK  in  1  scan clock, sole clock; all state updates on posedge.
REQ-002 SHALL have ports: TRST  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high at posedge.
REQ-004 SHALL have ports: cmd_is_ir  in  1  1 = IR scan, 0 = DR scan; cmd_len  in  6  bits to shift; cmd_data  in  36  shift vector, bit 0 shifted first.
REQ-005 SHALL have ports: TMS  out  1; TDI  out  1; TDO  in  1 (target TAP pins).
REQ-006 SHALL have ports: rsp_valid  out  1  one-cycle pulse; rsp_data  out  36  captured TDO bits.
REQ-007 SHALL have parameter: MAX_LEN, default 36, largest legal cmd_len.

Function
REQ-008 SHALL register TMS/TDI, changing only on posedge TCLK; the target samples them at the following posedge.
REQ-009 SHALL keep a mirror of the 16-state IEEE 1149.1 TAP FSM, advanced each posedge with the TMS value currently driven.
REQ-010 SHALL run an init sequence after reset: TMS=1 for 5 cycles (Test-Logic-Reset), then TMS=0 for 1 cycle (Run-Test/Idle).
REQ-011 SHALL assert cmd_ready only in IDLE (mirror in Run-Test/Idle, no scan pending), holding TMS=0, TDI=0.
REQ-012 SHALL, for DR, drive TMS 1,0,0 to reach Shift-DR; for IR, drive TMS 1,1,0,0 to reach Shift-IR.
REQ-013 SHALL drive cmd_data[i] on TDI for shift bit i, TMS=0 for bits 0..len-2 and TMS=1 with bit len-1 (enters Exit1).
REQ-014 SHALL then drive TMS=1 (Update), TMS=0 (Run-Test/Idle), returning to IDLE.
REQ-015 SHALL total scan length = len+5 cycles (DR) or len+6 cycles (IR), from acceptance to IDLE.
REQ-016 SHALL sample TDO at each posedge where the mirror is in Shift-DR/Shift-IR, storing sample i in rsp_data[i]; rsp_data[35:len] = 0.
REQ-017 SHALL pulse rsp_valid for one cycle on the edge returning to Run-Test/Idle; rsp_data holds until the next acceptance.
REQ-018 SHALL latch cmd_* at acceptance; input changes during a scan have no effect.
REQ-019 SHALL deassert cmd_ready during the init sequence and any scan; a command may be accepted the cycle after rsp_valid.
REQ-020 SHALL drive TDI=0 outside shift states.

Reset
REQ-021 SHALL, with TRST low: TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, mirror=Test-Logic-Reset, sequencer=INIT.
REQ-022 SHALL, on TRST assertion mid-scan, abandon the scan with no rsp_valid and rerun REQ-010 after release.

Configuration
REQ-023 SHALL support macro JTAG_SCAN_MASTER_LEN_CHECK_EN.
REQ-024 SHALL, with the macro defined, add output cmd_err (1 bit, reset 0): cmd_len 0 or >MAX_LEN is accepted, no TAP activity, next cycle rsp_valid=1, cmd_err=1, rsp_data=0; cmd_err=0 on legal responses.
REQ-025 SHALL, without the macro, have no cmd_err port and treat cmd_len 0 or >MAX_LEN as MAX_LEN.

Structure
REQ-026 SHALL place in shared package jtag_pkg: TAP state enum (16 states), MAX_LEN=36, IR_LEN=2.
REQ-027 SHALL implement the TAP next-state function in sub-module jtag_tap_mirror (state, TMS -> next state), reusable by the TAP controller.

Verification
REQ-028 SHALL test reset: TRST low 4 cycles -> TMS=1, cmd_ready=0; after release 5 TMS=1 + 1 TMS=0, cmd_ready=1 on cycle 7.
REQ-029 SHALL test IR: is_ir=1, len=2, data=2'b01 -> TMS 1,1,0,0,0,1,1,0; TDI 1 then 0 in Shift-IR; one rsp_valid after 8 cycles.
REQ-030 SHALL test DR: len=36, data=36'h0deadbeef, TDO tied 1 -> 41 cycles, TDI serial equals data LSB-first, rsp_data=36'hfffffffff.
REQ-031 SHALL test back-pressure: cmd_valid held through scan -> cmd_ready=0 throughout, second command accepted cycle after rsp_valid.
REQ-032 SHALL test mid-scan reset: TRST low at shift bit 10 of 36 -> no rsp_valid, TMS=1, init rerun, next command completes normally.
REQ-033 SHALL test macro: len=0 with JTAG_SCAN_MASTER_LEN_CHECK_EN -> cmd_err=1, rsp_valid=1, TMS stays 0; without macro -> 36-bit scan.

Source files
------------

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encoding and scan-master constants
package jtag_pkg;
  localparam int MAX_LEN = 36;
  localparam int IR_LEN = 2;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;
  typedef enum logic [1:0] {SQ_INIT, SQ_IDLE, SQ_SCAN} seq_t;
endpackage

// File: rtl/jtag_scan_master_if.sv
// jtag_scan_master_if: command/response handshake between a host and the scan master
// cmd_err exists only when JTAG_SCAN_MASTER_LEN_CHECK_EN is defined.
interface jtag_scan_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_is_ir;
  logic [5:0]  cmd_len;
  logic [35:0] cmd_data;
  logic        rsp_valid;
  logic [35:0] rsp_data;
`ifdef JTAG_SCAN_MASTER_LEN_CHECK_EN
  logic        cmd_err;
`endif
  modport master (
`ifdef JTAG_SCAN_MASTER_LEN_CHECK_EN
    input  cmd_err,
`endif
    output cmd_valid, cmd_is_ir, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );
  modport slave (
`ifdef JTAG_SCAN_MASTER_LEN_CHECK_EN
    output cmd_err,
`endif
    input  cmd_valid, cmd_is_ir, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_tap_mirror.sv
// jtag_tap_mirror: IEEE 1149.1 TAP next-state function (state, TMS -> next state)
module jtag_tap_mirror
  import jtag_pkg::*;
(
  input  tap_state_t state,
  input  logic       tms,
  output tap_state_t nxt
);
  always_comb begin
    nxt = TLR;
    case (state)
      TLR:      nxt = tms ? TLR      : RTI;
      RTI:      nxt = tms ? SEL_DR   : RTI;
      SEL_DR:   nxt = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   nxt = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: nxt = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: nxt = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: nxt = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: nxt = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   nxt = tms ? SEL_DR   : RTI;
      SEL_IR:   nxt = tms ? TLR      : CAP_IR;
      CAP_IR:   nxt = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: nxt = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: nxt = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: nxt = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: nxt = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   nxt = tms ? SEL_DR   : RTI;
      default:  nxt = TLR;
    endcase
  end
endmodule

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: IR/DR scan sequencer driving a JTAG TAP from latched commands
// JTAG_SCAN_MASTER_LEN_CHECK_EN rejects zero/oversize lengths with cmd_err instead of clamping.
module jtag_scan_master #(
  parameter int MAX_LEN = jtag_pkg::MAX_LEN
) (
  input  logic              TCLK,
  input  logic              TRST,
  jtag_scan_master_if.slave bus,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);
  import jtag_pkg::*;
  localparam logic [5:0] ML = 6'(MAX_LEN);
  seq_t seq, seq_n;
  tap_state_t tap, tap_n;
  logic [5:0] cnt, cnt_n, cnt_sh, len, len_n;
  logic ir, ir_n, tms_n, tdi_n, valid, valid_n, bad, chk, shift_now, shift_nxt;
  logic [35:0] data, data_n, rdata, rdata_n;

  jtag_tap_mirror u_mirror (.state(tap), .tms(TMS), .nxt(tap_n));

  assign bad = bus.cmd_len == '0 || bus.cmd_len > ML;
  assign shift_now = tap == SHIFT_DR || tap == SHIFT_IR;
  assign shift_nxt = tap_n == SHIFT_DR || tap_n == SHIFT_IR;
  assign cnt_sh = shift_now ? cnt + 6'd1 : cnt;
  assign bus.cmd_ready = seq == SQ_IDLE && tap == RTI;
  assign bus.rsp_valid = valid;
  assign bus.rsp_data = rdata;

`ifdef JTAG_SCAN_MASTER_LEN_CHECK_EN
  logic err;
  assign chk = bad;
  assign bus.cmd_err = err;
  // a response issued straight from IDLE is always a rejected command
  always_ff @(posedge TCLK or negedge TRST)
    if (!TRST) err <= 1'b0;
    else if (valid_n) err <= seq == SQ_IDLE;
`else
  assign chk = 1'b0;
`endif

  // TMS/TDI for the next edge are chosen from the state the mirror is about to enter
  always_comb begin
    seq_n = seq;
    cnt_n = cnt;
    len_n = len;
    ir_n = ir;
    data_n = data;
    tms_n = 1'b0;
    tdi_n = 1'b0;
    valid_n = 1'b0;
    rdata_n = rdata;
    case (seq)
      SQ_INIT: begin
        cnt_n = cnt == 6'd5 ? '0 : cnt + 6'd1;
        tms_n = cnt < 6'd4;
        seq_n = cnt == 6'd5 ? SQ_IDLE : SQ_INIT;
      end
      SQ_IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
        rdata_n = '0;
        valid_n = chk;
        seq_n = chk ? SQ_IDLE : SQ_SCAN;
        tms_n = !chk;
        cnt_n = '0;
        len_n = bad ? ML : bus.cmd_len;
        ir_n = bus.cmd_is_ir;
        data_n = bus.cmd_data;
      end
      SQ_SCAN: begin
        if (shift_now) rdata_n[cnt] = TDO;
        cnt_n = cnt_sh;
        tms_n = tap_n == SEL_DR ? ir
              : shift_nxt ? (cnt_sh == len - 6'd1)
              : (tap_n == EXIT1_DR || tap_n == EXIT1_IR);
        tdi_n = shift_nxt && data[cnt_sh];
        valid_n = tap_n == RTI;
        seq_n = tap_n == RTI ? SQ_IDLE : SQ_SCAN;
      end
      default: seq_n = SQ_INIT;
    endcase
  end

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      seq <= SQ_INIT;
      tap <= TLR;
      cnt <= '0;
      len <= '0;
      ir <= 1'b0;
      data <= '0;
      TMS <= 1'b1;
      TDI <= 1'b0;
      valid <= 1'b0;
      rdata <= '0;
    end else begin
      seq <= seq_n;
      tap <= tap_n;
      cnt <= cnt_n;
      len <= len_n;
      ir <= ir_n;
      data <= data_n;
      TMS <= tms_n;
      TDI <= tdi_n;
      valid <= valid_n;
      rdata <= rdata_n;
    end
  end
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: directed checks of init, IR/DR scans, back-pressure, mid-scan reset, length handling
module tb_jtag_scan_master;
  logic TCLK = 1'b0;
  logic TRST = 1'b0;
  logic TMS, TDI, TDO;
  logic tdo_loop = 1'b1;
  logic tdo_val = 1'b0;
  logic [7:0] ir_tms = 8'b0110_0011;
  logic [7:0] ir_tdi = 8'b0001_0000;
  int checks = 0;
  int errors = 0;

  jtag_scan_master_if bus();
  jtag_scan_master dut (.TCLK(TCLK), .TRST(TRST), .bus(bus), .TMS(TMS), .TDI(TDI), .TDO(TDO));

  assign TDO = tdo_loop ? TDI : tdo_val;
  always #5 TCLK = ~TCLK;

  task automatic tick();
    @(posedge TCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_seq();
    chk("init_tms_pre", 36'(TMS), 36'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("init_tms", 36'(TMS), 36'(k < 5));
      chk("init_ready", 36'(bus.cmd_ready), 36'd0);
    end
    tick();
    chk("init_ready_c7", 36'(bus.cmd_ready), 36'd1);
    chk("init_pins_idle", 36'({TMS, TDI}), 36'd0);
  endtask

  task automatic issue(input logic ir, input logic [5:0] len, input logic [35:0] d, input bit hold);
    bus.cmd_is_ir = ir;
    bus.cmd_len = len;
    bus.cmd_data = d;
    bus.cmd_valid = 1'b1;
    chk("issue_ready", 36'(bus.cmd_ready), 36'd1);
    tick();
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  // independent TMS/TDI model: prefix 1,0,0 (DR) or 1,1,0,0 (IR), len shift bits, then 1,0
  task automatic scan(input string tag, input bit ir, input int len, input logic [35:0] d, input logic [35:0] exp);
    int pre, n;
    logic et, ed;
    pre = ir ? 4 : 3;
    n = pre + len + 2;
    for (int k = 0; k < n; k++) begin
      et = (k < pre) ? (k == 0 || (ir && k == 1))
         : (k < pre + len) ? (k == pre + len - 1) : (k == pre + len);
      ed = (k >= pre && k < pre + len) ? d[k - pre] : 1'b0;
      chk({tag, "_pins"}, 36'({TMS, TDI}), 36'({et, ed}));
      chk({tag, "_busy"}, 36'({bus.cmd_ready, bus.rsp_valid}), 36'd0);
      tick();
    end
    chk({tag, "_valid"}, 36'(bus.rsp_valid), 36'd1);
    chk({tag, "_data"}, bus.rsp_data, exp);
    chk({tag, "_ready"}, 36'(bus.cmd_ready), 36'd1);
`ifdef JTAG_SCAN_MASTER_LEN_CHECK_EN
    chk({tag, "_err"}, 36'(bus.cmd_err), 36'd0);
`endif
    tick();
    chk({tag, "_pulse"}, 36'(bus.rsp_valid), 36'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_is_ir = 1'b0;
    bus.cmd_len = '0;
    bus.cmd_data = '0;
    repeat (4) tick();
    chk("rst_tms", 36'(TMS), 36'd1);
    chk("rst_tdi", 36'(TDI), 36'd0);
    chk("rst_ready", 36'(bus.cmd_ready), 36'd0);
    chk("rst_valid", 36'(bus.rsp_valid), 36'd0);
    chk("rst_data", bus.rsp_data, 36'd0);
    TRST = 1'b1;
    init_seq();

    // IR len 2, data 01, loopback TDO
    issue(1'b1, 6'd2, 36'h1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("ir_tms", 36'(TMS), 36'(ir_tms[k]));
      chk("ir_tdi", 36'(TDI), 36'(ir_tdi[k]));
      chk("ir_busy", 36'({bus.cmd_ready, bus.rsp_valid}), 36'd0);
      tick();
    end
    chk("ir_valid", 36'(bus.rsp_valid), 36'd1);
    chk("ir_data", bus.rsp_data, 36'h1);
    chk("ir_ready", 36'(bus.cmd_ready), 36'd1);
    tick();
    chk("ir_pulse", 36'(bus.rsp_valid), 36'd0);

    // DR 36 with cmd_valid held; inputs change mid-scan to form the second command
    tdo_loop = 1'b0;
    tdo_val = 1'b1;
    issue(1'b0, 6'd36, 36'h0deadbeef, 1'b1);
    bus.cmd_len = 6'd3;
    bus.cmd_data = 36'h5;
    scan("dr36", 1'b0, 36, 36'h0deadbeef, 36'hfffffffff);
    bus.cmd_valid = 1'b0;
    tdo_loop = 1'b1;
    scan("bp2", 1'b0, 3, 36'h5, 36'h5);

    // reset while bit 10 of a 36-bit DR shift is on TDI
    issue(1'b0, 6'd36, 36'h123456789, 1'b0);
    repeat (13) tick();
    chk("mr_tdi_bit10", 36'(TDI), 36'd1);
    TRST = 1'b0;
    #1;
    chk("mr_tms", 36'(TMS), 36'd1);
    chk("mr_tdi", 36'(TDI), 36'd0);
    chk("mr_ready", 36'(bus.cmd_ready), 36'd0);
    chk("mr_data", bus.rsp_data, 36'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_valid", 36'(bus.rsp_valid), 36'd0);
      chk("mr_tms_held", 36'(TMS), 36'd1);
    end
    TRST = 1'b1;
    init_seq();
    issue(1'b0, 6'd8, 36'ha5, 1'b0);
    scan("post_rst", 1'b0, 8, 36'ha5, 36'ha5);

`ifdef JTAG_SCAN_MASTER_LEN_CHECK_EN
    issue(1'b0, 6'd0, 36'hfff, 1'b0);
    chk("len0_valid", 36'(bus.rsp_valid), 36'd1);
    chk("len0_err", 36'(bus.cmd_err), 36'd1);
    chk("len0_data", bus.rsp_data, 36'd0);
    chk("len0_pins", 36'({TMS, TDI}), 36'd0);
    tick();
    chk("len0_pulse", 36'(bus.rsp_valid), 36'd0);
    chk("len0_tms", 36'(TMS), 36'd0);
    chk("len0_ready", 36'(bus.cmd_ready), 36'd1);
    issue(1'b1, 6'd2, 36'h2, 1'b0);
    scan("after_err", 1'b1, 2, 36'h2, 36'h2);
`else
    issue(1'b0, 6'd0, 36'h9abcdef01, 1'b0);
    scan("len0", 1'b0, 36, 36'h9abcdef01, 36'h9abcdef01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
